dot_accumulator: RTL and testbench

- Downstream consumer of the `vedic32x32` multiplier.
- Accepts a stream of unsigned 64-bit products with a valid/ready handshake and sums them into a wide accumulator.
- On the beat tagged `p_last`, emits the finished dot product, which is one element of the result matrix, through a one-entry output register with its own valid/ready handshake.
- Sits between the multiplier and the result-matrix writer in the matrix-multiply datapath.

---
 rtl/dot_accumulator.sv | 110 +++++++++++
 tb/tb_dot_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dot_accumulator                                               |
// | Brief    : Sums a stream of unsigned products into a wide accumulator and |
// |            presents each finished dot product through a one-entry        |
// |            valid/ready output register.                                  |
// | Options  : DOT_ACC_SATURATE_EN - clamp the sum on overflow (default wrap) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dot_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PROD_W-1:0] p_data,
  input  logic              p_last,
  output logic              dot_valid,
  input  logic              dot_ready,
  output logic [ACC_W-1:0]  dot_data,
  output logic [CNT_W-1:0]  dot_count,
  output logic              dot_ovf
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;

  logic               accept;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W:0]     raw_sum;
  logic               next_ovf;
  logic [ACC_W-1:0]   next_acc;
  logic [CNT_W-1:0]   next_cnt;

  // The output register can always take a new result unless it is stalled.
  assign p_ready = !(dot_valid && !dot_ready);
  assign accept  = p_valid && p_ready;

  // Next partial sum, count and overflow for a beat accepted this cycle.
  always_comb begin
    base     = (state == ACCUM) ? acc : '0;
    addend   = ACC_W'(p_data);
    raw_sum  = {1'b0, base} + {1'b0, addend};
    // Sticky flag is only ever set while accumulating, so EMPTY contributes 0.
    next_ovf = ovf_sticky || raw_sum[ACC_W];
`ifdef DOT_ACC_SATURATE_EN
    // Once clamped, the sum stays at full scale for the rest of this product.
    next_acc = next_ovf ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
    next_acc = raw_sum[ACC_W-1:0];
`endif
    if (state == EMPTY) begin
      next_cnt = CNT_W'(1);
    end else if (cnt == {CNT_W{1'b1}}) begin
      next_cnt = cnt;
    end else begin
      next_cnt = cnt + CNT_W'(1);
    end
  end

  // Accumulator FSM plus the one-entry result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      dot_valid  <= 1'b0;
      dot_data   <= '0;
      dot_count  <= '0;
      dot_ovf    <= 1'b0;
    end else begin
      if (accept) begin
        if (p_last) begin
          dot_data   <= next_acc;
          dot_count  <= next_cnt;
          dot_ovf    <= next_ovf;
          state      <= EMPTY;
          acc        <= '0;
          cnt        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= next_acc;
          cnt        <= next_cnt;
          ovf_sticky <= next_ovf;
          state      <= ACCUM;
        end
      end
      // A last beat reloads the register even as the old result drains.
      if (accept && p_last) begin
        dot_valid <= 1'b1;
      end else if (dot_ready) begin
        dot_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dot_accumulator                                            |
// | Brief    : Self-checking bench for dot_accumulator.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dot_accumulator;
  localparam int PROD_W = 64;
  localparam int ACC_W  = 72;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p_valid = 1'b0;
  logic              p_ready;
  logic [PROD_W-1:0] p_data = '0;
  logic              p_last = 1'b0;
  logic              dot_valid;
  logic              dot_ready = 1'b1;
  logic [ACC_W-1:0]  dot_data;
  logic [CNT_W-1:0]  dot_count;
  logic              dot_ovf;

  dot_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data), .p_last(p_last),
    .dot_valid(dot_valid), .dot_ready(dot_ready),
    .dot_data(dot_data), .dot_count(dot_count), .dot_ovf(dot_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the exact (unbounded) running total of the current dot product and
  // derives the result from it: overflow means the true sum exceeds ACC_W bits.
  logic [127:0]     m_sum = '0;
  int               m_terms = 0;
  bit               m_valid = 1'b0;
  bit               m_show  = 1'b0;
  bit               mon_en  = 1'b0;
  logic [ACC_W-1:0] m_data  = '0;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_ovf   = 1'b0;

  // Compare outputs, then advance the model by what the next edge will see.
  always @(negedge clk) begin
    logic [127:0] total;
    bit           ovf;
    bit           acc_ok;
    if (mon_en) begin
      chk("p_ready", p_ready, !(m_valid && !dot_ready));
      chk("dot_valid", dot_valid, m_valid);
      if (m_show) begin
        chk("dot_data", dot_data, m_data);
        chk("dot_count", dot_count, m_count);
        chk("dot_ovf", dot_ovf, m_ovf);
      end
    end
    if (rst) begin
      m_sum = '0; m_terms = 0; m_valid = 1'b0; m_show = 1'b1;
      m_data = '0; m_count = '0; m_ovf = 1'b0;
    end else begin
      acc_ok = p_valid && !(m_valid && !dot_ready);
      if (acc_ok && p_last) begin
        total = m_sum + 128'(p_data);
        ovf   = (total >> ACC_W) != 0;
`ifdef DOT_ACC_SATURATE_EN
        m_data = ovf ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
        m_data = total[ACC_W-1:0];
`endif
        m_count = (m_terms + 1 > 511) ? CNT_W'(511) : CNT_W'(m_terms + 1);
        m_ovf   = ovf;
        m_valid = 1'b1;
        m_show  = 1'b1;
        m_sum   = '0;
        m_terms = 0;
      end else begin
        if (acc_ok) begin
          m_sum   = m_sum + 128'(p_data);
          m_terms = m_terms + 1;
        end
        if (dot_ready && m_valid) begin
          m_valid = 1'b0;
          m_show  = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [PROD_W-1:0] d, input logic last);
    int n;
    n = 0;
    p_valid = 1'b1; p_data = d; p_last = last;
    @(negedge clk);
    while (!p_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!p_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: got p_ready=%0b expected 1", p_ready);
    end
    @(posedge clk); #1;
    p_valid = 1'b0; p_last = 1'b0;
  endtask

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", dot_valid, 0);
    chk("reset_data", dot_data, 0);
    chk("reset_p_ready", p_ready, 1);
    @(posedge clk); #1;

    // Basic sum
    send(10, 0); send(20, 0); send(30, 1);
    @(negedge clk);
    chk("s1_valid", dot_valid, 1);
    chk("s1_data", dot_data, 60);
    chk("s1_count", dot_count, 3);
    chk("s1_ovf", dot_ovf, 0);
    @(negedge clk);
    chk("s1_valid_one_cycle", dot_valid, 0);
    @(posedge clk); #1;

    // Single-term max
    send(ONES64, 1);
    @(negedge clk);
    chk("s2_data", dot_data, 72'h00_FFFF_FFFF_FFFF_FFFF);
    chk("s2_count", dot_count, 1);
    @(posedge clk); #1;

    // Backpressure
    dot_ready = 1'b0;
    send(10, 0); send(20, 0); send(30, 1);
    @(negedge clk);
    chk("s3_valid", dot_valid, 1);
    chk("s3_p_ready_low", p_ready, 0);
    chk("s3_data", dot_data, 60);
    repeat (3) @(negedge clk);
    chk("s3_data_held", dot_data, 60);
    chk("s3_count_held", dot_count, 3);
    chk("s3_p_ready_held_low", p_ready, 0);
    @(posedge clk); #1;
    dot_ready = 1'b1;
    #1;
    chk("s3_p_ready_rise", p_ready, 1);
    send(4, 0); send(5, 1);
    @(negedge clk);
    chk("s3_data_next", dot_data, 9);
    chk("s3_count_next", dot_count, 2);
    @(posedge clk); #1;

    // Overflow
    repeat (256) send(ONES64, 0);
    send(ONES64, 1);
    @(negedge clk);
    chk("s4_count", dot_count, 257);
    chk("s4_ovf", dot_ovf, 1);
`ifdef DOT_ACC_SATURATE_EN
    chk("s4_data", dot_data, 72'hFF_FFFF_FFFF_FFFF_FFFF);
`else
    chk("s4_data", dot_data, 72'h00_FFFF_FFFF_FFFF_FEFF);
`endif
    @(posedge clk); #1;

    // Reset mid-operation
    send(100, 0); send(200, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_rst_valid", dot_valid, 0);
    chk("s5_rst_data", dot_data, 0);
    chk("s5_rst_count", dot_count, 0);
    chk("s5_rst_ovf", dot_ovf, 0);
    chk("s5_rst_p_ready", p_ready, 1);
    @(posedge clk); #1;
    send(7, 1);
    @(negedge clk);
    chk("s5_data", dot_data, 7);
    chk("s5_count", dot_count, 1);
    @(posedge clk); #1;

    // Back-to-back
    p_valid = 1'b1; p_data = 3; p_last = 1'b1;
    @(negedge clk);
    chk("s6_p_ready0", p_ready, 1);
    @(posedge clk); #1;
    p_data = 4;
    @(negedge clk);
    chk("s6_data3", dot_data, 3);
    chk("s6_valid3", dot_valid, 1);
    chk("s6_p_ready1", p_ready, 1);
    @(posedge clk); #1;
    p_data = 5; p_last = 1'b0;
    @(negedge clk);
    chk("s6_data4", dot_data, 4);
    chk("s6_valid4", dot_valid, 1);
    chk("s6_p_ready2", p_ready, 1);
    @(posedge clk); #1;
    p_data = 6; p_last = 1'b1;
    @(negedge clk);
    chk("s6_gap_valid", dot_valid, 0);
    chk("s6_p_ready3", p_ready, 1);
    @(posedge clk); #1;
    p_valid = 1'b0; p_last = 1'b0;
    @(negedge clk);
    chk("s6_data11", dot_data, 11);
    chk("s6_count11", dot_count, 2);
    chk("s6_valid11", dot_valid, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
